// File: rtl/snn_layer_sequencer.sv
// ============================================================================
// Module      : snn_layer_sequencer
// Description : Steps a programmed layer-slot table over N timesteps, issuing
//               one execute command per slot to the layer manager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_layer_sequencer #(
    parameter int MAX_LAYERS = 16,
    parameter int TS_WIDTH   = 16,
    parameter int TO_WIDTH   = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                seq_wr_en,
    input  logic [3:0]          seq_wr_idx,
    input  logic [7:0]          seq_wr_layer,
    input  logic [4:0]          num_steps,
    input  logic [TS_WIDTH-1:0] num_timesteps,
    input  logic [TO_WIDTH-1:0] timeout_limit,
    input  logic                start,
    input  logic                abort,
    input  logic                clear_err,
    output logic [7:0]          execute_layer_id,
    output logic                execute_start,
    input  logic                execute_done,
    output logic                busy,
    output logic                seq_done,
    output logic                timestep_done,
    output logic [3:0]          cur_step,
    output logic [TS_WIDTH-1:0] cur_timestep,
    output logic                error,
    output logic [1:0]          err_code
);

    localparam logic [8:0] c_max_id    = 9'(MAX_LAYERS);
    localparam logic [4:0] c_max_steps = 5'(MAX_LAYERS);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_NEXT      = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          table_q [MAX_LAYERS];
    logic [3:0]          step_q, step_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic [4:0]          ns_q, ns_d;
    logic [TS_WIDTH-1:0] nts_q, nts_d;
    logic [TO_WIDTH-1:0] lim_q, lim_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d;
    logic [7:0]          layer_id_q, layer_id_d;
    logic                exec_start_q, exec_start_d;
    logic                busy_q, busy_d;
    logic                seq_done_q, seq_done_d;
    logic                ts_done_q, ts_done_d;
    logic                error_q, error_d;
    logic [1:0]          err_code_q, err_code_d;

    logic                wr_ok;
    logic                enter_issue;
    logic                last_step;
    logic                last_ts;
    logic                wd_fire;
    logic [TO_WIDTH-1:0] wd_inc;
    logic [7:0]          next_entry;

    assign wr_ok = seq_wr_en && !busy_q && !error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                table_q[i] <= 8'hFF;
            end
        end else if (wr_ok) begin
            table_q[seq_wr_idx] <= seq_wr_layer;
        end
    end

    assign last_step = ({1'b0, step_q} == (ns_q - 5'd1));
    assign last_ts   = (ts_q == (nts_q - TS_WIDTH'(1)));
    assign wd_inc    = (wd_q == {TO_WIDTH{1'b1}}) ? wd_q : wd_q + TO_WIDTH'(1);
    assign wd_fire   = (lim_q != '0) && (wd_inc == lim_q);

    // The command pulse is registered, so the table is read one cycle ahead,
    // bypassing a same-cycle write so the issued id matches the table.
    assign next_entry = (wr_ok && (seq_wr_idx == step_d)) ? seq_wr_layer : table_q[step_d];

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        ts_d         = ts_q;
        ns_d         = ns_q;
        nts_d        = nts_q;
        lim_d        = lim_q;
        wd_d         = wd_q;
        layer_id_d   = layer_id_q;
        exec_start_d = 1'b0;
        seq_done_d   = 1'b0;
        ts_done_d    = 1'b0;
        err_code_d   = err_code_q;
        enter_issue  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((num_steps == 5'd0) || (num_timesteps == '0)) begin
                        seq_done_d = 1'b1;
                    end else begin
                        state_d     = S_ISSUE;
                        step_d      = 4'd0;
                        ts_d        = '0;
                        ns_d        = (num_steps > c_max_steps) ? c_max_steps : num_steps;
                        nts_d       = num_timesteps;
                        lim_d       = timeout_limit;
                        enter_issue = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                // No pulse was launched on entry means the slot held a bad id.
                if (!exec_start_q) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd3;
                end else begin
                    state_d = S_WAIT_ACK;
                    wd_d    = '0;
                end
            end
            S_WAIT_ACK: begin
                wd_d = wd_inc;
                if (!execute_done) begin
                    state_d = S_WAIT_DONE;
                    wd_d    = '0;
                end else if (wd_fire) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd1;
                end
            end
            S_WAIT_DONE: begin
                wd_d = wd_inc;
                if (execute_done) begin
                    state_d    = S_NEXT;
                    ts_done_d  = last_step;
                    seq_done_d = last_step && last_ts;
                end else if (wd_fire) begin
                    state_d    = S_ERROR;
                    err_code_d = 2'd2;
                end
            end
            S_NEXT: begin
                if (last_step) begin
                    step_d = 4'd0;
                    if (last_ts) begin
                        state_d = S_IDLE;
                    end else begin
                        ts_d        = ts_q + TS_WIDTH'(1);
                        state_d     = S_ISSUE;
                        enter_issue = 1'b1;
                    end
                end else begin
                    step_d      = step_q + 4'd1;
                    state_d     = S_ISSUE;
                    enter_issue = 1'b1;
                end
            end
            S_ERROR: begin
                if (clear_err) begin
                    state_d    = S_IDLE;
                    err_code_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE) && (state_q != S_ERROR)) begin
            state_d     = S_IDLE;
            enter_issue = 1'b0;
            seq_done_d  = 1'b0;
            ts_done_d   = 1'b0;
            err_code_d  = err_code_q;
        end

        if (enter_issue && ({1'b0, next_entry} < c_max_id)) begin
            exec_start_d = 1'b1;
            layer_id_d   = next_entry;
        end

        busy_d  = (state_d == S_ISSUE) || (state_d == S_WAIT_ACK) ||
                  (state_d == S_WAIT_DONE) || (state_d == S_NEXT);
        error_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            step_q       <= 4'd0;
            ts_q         <= '0;
            ns_q         <= 5'd0;
            nts_q        <= '0;
            lim_q        <= '0;
            wd_q         <= '0;
            layer_id_q   <= 8'h00;
            exec_start_q <= 1'b0;
            busy_q       <= 1'b0;
            seq_done_q   <= 1'b0;
            ts_done_q    <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            ts_q         <= ts_d;
            ns_q         <= ns_d;
            nts_q        <= nts_d;
            lim_q        <= lim_d;
            wd_q         <= wd_d;
            layer_id_q   <= layer_id_d;
            exec_start_q <= exec_start_d;
            busy_q       <= busy_d;
            seq_done_q   <= seq_done_d;
            ts_done_q    <= ts_done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    assign execute_layer_id = layer_id_q;
    assign execute_start    = exec_start_q;
    assign busy             = busy_q;
    assign seq_done         = seq_done_q;
    assign timestep_done    = ts_done_q;
    assign cur_step         = step_q;
    assign cur_timestep     = ts_q;
    assign error            = error_q;
    assign err_code         = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_snn_layer_sequencer.sv
// ============================================================================
// Module      : tb_snn_layer_sequencer
// Description : Directed self-checking bench with a reactive layer-manager model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snn_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seq_wr_en = 1'b0;
    logic [3:0]  seq_wr_idx = 4'd0;
    logic [7:0]  seq_wr_layer = 8'd0;
    logic [4:0]  num_steps = 5'd0;
    logic [15:0] num_timesteps = 16'd0;
    logic [19:0] timeout_limit = 20'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        clear_err = 1'b0;
    logic [7:0]  execute_layer_id;
    logic        execute_start;
    logic        execute_done;
    logic        busy;
    logic        seq_done;
    logic        timestep_done;
    logic [3:0]  cur_step;
    logic [15:0] cur_timestep;
    logic        error;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;

    snn_layer_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .seq_wr_en        (seq_wr_en),
        .seq_wr_idx       (seq_wr_idx),
        .seq_wr_layer     (seq_wr_layer),
        .num_steps        (num_steps),
        .num_timesteps    (num_timesteps),
        .timeout_limit    (timeout_limit),
        .start            (start),
        .abort            (abort),
        .clear_err        (clear_err),
        .execute_layer_id (execute_layer_id),
        .execute_start    (execute_start),
        .execute_done     (execute_done),
        .busy             (busy),
        .seq_done         (seq_done),
        .timestep_done    (timestep_done),
        .cur_step         (cur_step),
        .cur_timestep     (cur_timestep),
        .error            (error),
        .err_code         (err_code)
    );

    always #5 clk = ~clk;

    // Layer manager: drops done after a command, raises it MGR_LAT cycles later.
    localparam int MGR_LAT = 4;
    logic mgr_hold = 1'b0;
    int   mgr_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            execute_done <= 1'b1;
            mgr_cnt      <= 0;
        end else if (mgr_hold) begin
            execute_done <= 1'b1;
        end else if (execute_start) begin
            execute_done <= 1'b0;
            mgr_cnt      <= MGR_LAT - 1;
        end else if (mgr_cnt != 0) begin
            mgr_cnt <= mgr_cnt - 1;
        end else begin
            execute_done <= 1'b1;
        end
    end

    int       cyc = 0;
    int       n_pulse = 0;
    int       n_tsd = 0;
    int       n_sd = 0;
    int       n_both = 0;
    logic [7:0] ids [64];
    int       pcyc [64];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rst_n) begin
            if (execute_start && n_pulse < 64) begin
                ids[n_pulse]  = execute_layer_id;
                pcyc[n_pulse] = cyc;
                n_pulse = n_pulse + 1;
            end
            if (timestep_done) n_tsd = n_tsd + 1;
            if (seq_done) n_sd = n_sd + 1;
            if (timestep_done && seq_done) n_both = n_both + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [3:0] idx, input logic [7:0] lyr);
        seq_wr_en = 1'b1; seq_wr_idx = idx; seq_wr_layer = lyr;
        tick(1);
        seq_wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] ns, input logic [15:0] nts, input logic [19:0] lim);
        num_steps = ns; num_timesteps = nts; timeout_limit = lim;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_sig(input string tag, input int which, input int budget);
        int   k = 0;
        logic v;
        v = (which == 0) ? execute_start : (which == 1) ? seq_done : error;
        while (v !== 1'b1 && k < budget) begin
            tick(1);
            k++;
            v = (which == 0) ? execute_start : (which == 1) ? seq_done : error;
        end
        chk(tag, {63'd0, v}, 64'd1);
    endtask

    function automatic logic [63:0] outs();
        return {29'd0, execute_layer_id, execute_start, busy, seq_done, timestep_done,
                cur_step, cur_timestep, error, err_code};
    endfunction

    initial begin
        int base;
        int sd_base;
        logic [7:0] exp_ids [6];
        exp_ids[0] = 8'd2; exp_ids[1] = 8'd5; exp_ids[2] = 8'd2;
        exp_ids[3] = 8'd5; exp_ids[4] = 8'd2; exp_ids[5] = 8'd5;

        // Reset state
        tick(3);
        chk("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        tick(1);

        wr(4'd0, 8'd2);
        wr(4'd1, 8'd5);

        // Two steps, three timesteps
        base = n_pulse; sd_base = n_sd;
        start_run(5'd2, 16'd3, 20'd0);
        chk("first_issue_start", {63'd0, execute_start}, 64'd1);
        chk("first_issue_id", {56'd0, execute_layer_id}, 64'd2);
        chk("first_issue_busy", {63'd0, busy}, 64'd1);
        wait_sig("run1_seq_done", 1, 300);
        chk("run1_tsd_with_sd", {63'd0, timestep_done}, 64'd1);
        chk("run1_pulses", 64'(n_pulse - base), 64'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("run1_id%0d", i), {56'd0, ids[base + i]}, {56'd0, exp_ids[i]});
        end
        chk("run1_pulse_gap", 64'(pcyc[base + 1] - pcyc[base]), 64'd7);
        tick(1);
        chk("run1_tsd_count", 64'(n_tsd), 64'd3);
        chk("run1_sd_count", 64'(n_sd - sd_base), 64'd1);
        chk("run1_both_count", 64'(n_both), 64'd1);
        chk("run1_busy_after", {63'd0, busy}, 64'd0);

        // Zero steps
        base = n_pulse;
        start_run(5'd0, 16'd3, 20'd0);
        chk("zero_seq_done", {63'd0, seq_done}, 64'd1);
        chk("zero_busy", {63'd0, busy}, 64'd0);
        tick(1);
        chk("zero_seq_done_drop", {63'd0, seq_done}, 64'd0);
        chk("zero_no_pulse", 64'(n_pulse - base), 64'd0);

        // Table write during busy must not land
        start_run(5'd2, 16'd1, 20'd0);
        tick(2);
        wr(4'd0, 8'd7);
        wait_sig("lock_seq_done", 1, 100);
        tick(2);

        // Abort during the second WAIT_DONE
        base = n_pulse;
        start_run(5'd2, 16'd3, 20'd0);
        chk("lock_id_unchanged", {56'd0, execute_layer_id}, 64'd2);
        tick(1);
        wait_sig("abort_second_pulse", 0, 20);
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        base = n_pulse; sd_base = n_sd;
        tick(15);
        chk("abort_no_pulses", 64'(n_pulse - base), 64'd0);
        chk("abort_no_seq_done", 64'(n_sd - sd_base), 64'd0);
        start_run(5'd2, 16'd1, 20'd0);
        chk("rerun_start", {63'd0, execute_start}, 64'd1);
        chk("rerun_id", {56'd0, execute_layer_id}, 64'd2);
        chk("rerun_step_ts", {44'd0, cur_step, cur_timestep}, 64'd0);
        wait_sig("rerun_seq_done", 1, 100);
        tick(2);

        // Ack timeout
        mgr_hold = 1'b1;
        start_run(5'd1, 16'd1, 20'd8);
        tick(1);
        tick(7);
        chk("ackto_not_yet", {62'd0, error, busy}, 64'd1);
        tick(1);
        chk("ackto_error", {61'd0, error, err_code}, 64'h5);
        chk("ackto_busy", {63'd0, busy}, 64'd0);
        base = n_pulse;
        start_run(5'd1, 16'd1, 20'd0);
        chk("err_start_ignored", {62'd0, error, busy}, 64'd2);
        chk("err_no_pulse", 64'(n_pulse - base), 64'd0);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        chk("clear_err", {60'd0, busy, error, err_code}, 64'd0);
        mgr_hold = 1'b0;

        // Bad layer id in entry 1
        wr(4'd1, 8'h20);
        base = n_pulse;
        start_run(5'd2, 16'd1, 20'd0);
        wait_sig("badid_error", 2, 50);
        chk("badid_code", {62'd0, err_code}, 64'd3);
        chk("badid_pulses", 64'(n_pulse - base), 64'd1);
        chk("badid_pulse_id", {56'd0, ids[base]}, 64'd2);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;

        // Asynchronous reset mid-run
        start_run(5'd1, 16'd3, 20'd0);
        tick(3);
        chk("midrun_busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        base = n_pulse;
        start_run(5'd1, 16'd1, 20'd0);
        chk("post_reset_no_pulse", {63'd0, execute_start}, 64'd0);
        tick(1);
        chk("post_reset_table_ff", {61'd0, error, err_code}, 64'h7);
        chk("post_reset_pulses", 64'(n_pulse - base), 64'd0);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
